// File: rtl/audio_pkg.sv
// audio_pkg: shared sample types for the audio path
package audio_pkg;
    localparam int AUDIO_W = 18;
    typedef logic signed [AUDIO_W-1:0] sample_t;
    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;
endpackage

// File: rtl/audio_iir1.sv
// audio_iir1: one-channel first-order IIR low-pass (alpha = 2^-SHIFT) plus raw sample hold
module audio_iir1
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_W,
    parameter int SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in,
    output logic signed [WIDTH-1:0] filt,
    output logic signed [WIDTH-1:0] raw
);
    localparam int AW = WIDTH + SHIFT;
    logic signed [AW-1:0] acc;
    logic signed [AW:0]   diff;
    // one guard bit keeps target - acc exact; the shifted step always fits AW bits
    assign diff = $signed({in[WIDTH-1], in, {SHIFT{1'b0}}}) - $signed({acc[AW-1], acc});
    assign filt = acc[AW-1:SHIFT];
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            raw <= '0;
        end else if (in_valid) begin
            acc <= acc + AW'(diff >>> SHIFT);
            raw <= in;
        end
    end
endmodule

// File: rtl/audio_rate_adapter.sv
// audio_rate_adapter: low-pass each channel and resample onto an exact-average RATE_HZ grid
module audio_rate_adapter
    import audio_pkg::*;
#(
    parameter int CLK_HZ  = 31527954,
    parameter int RATE_HZ = 48000,
    parameter int WIDTH   = AUDIO_W,
    parameter int SHIFT   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_l,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic                    bypass,
    output logic signed [WIDTH-1:0] out_l,
    output logic signed [WIDTH-1:0] out_r,
    output logic                    out_valid,
    output logic                    tick
);
    localparam int PW = $clog2(CLK_HZ + RATE_HZ);
    logic [PW-1:0] phase, phase_sum;
    logic signed [WIDTH-1:0] filt_l, filt_r, raw_l, raw_r;
    assign phase_sum = phase + PW'(RATE_HZ);
    assign tick = phase_sum >= PW'(CLK_HZ);
    // the output samples the filter/raw registers before this edge's in_valid update lands
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            phase     <= tick ? phase_sum - PW'(CLK_HZ) : phase_sum;
            out_valid <= tick;
            if (tick) begin
                out_l <= bypass ? raw_l : filt_l;
                out_r <= bypass ? raw_r : filt_r;
            end
        end
    end
    audio_iir1 #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_l), .filt(filt_l), .raw(raw_l)
    );
    audio_iir1 #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_r (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_r), .filt(filt_r), .raw(raw_r)
    );
endmodule

// File: tb/tb_audio_rate_adapter.sv
// tb_audio_rate_adapter: scoreboard bench for two adapter instances (SHIFT=1 and SHIFT=3) on a 3-per-10 grid
module tb_audio_rate_adapter;
    localparam int C = 10;
    localparam int R = 3;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, bypass = 1'b0;
    logic signed [17:0] in_l = '0, in_r = '0;
    logic signed [17:0] out_l_a, out_r_a, out_l_b, out_r_b;
    logic out_valid_a, out_valid_b, tick_a, tick_b;
    typedef struct { longint la, ra, lb, rb; } exp_t;
    exp_t q[$];
    int total = 0, bad = 0, mph = 0;
    longint macc [2][2];
    longint mraw [2][2];
    bit exp_v = 0;

    always #5 clk = ~clk;

    audio_rate_adapter #(.CLK_HZ(C), .RATE_HZ(R), .WIDTH(18), .SHIFT(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_l(in_l), .in_r(in_r), .bypass(bypass),
        .out_l(out_l_a), .out_r(out_r_a), .out_valid(out_valid_a), .tick(tick_a)
    );
    audio_rate_adapter #(.CLK_HZ(C), .RATE_HZ(R), .WIDTH(18), .SHIFT(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_l(in_l), .in_r(in_r), .bypass(bypass),
        .out_l(out_l_b), .out_r(out_r_b), .out_valid(out_valid_b), .tick(tick_b)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint mout(int i, int c);
        return bypass ? mraw[i][c] : (macc[i][c] >>> (i ? 3 : 1));
    endfunction

    // one clock: advance the reference model at the edge, then check the DUTs 1 time unit later
    task automatic cyc();
        exp_t e;
        bit t;
        longint x;
        int s;
        @(posedge clk);
        t = !reset && (mph + R >= C);
        if (t) begin
            e = '{mout(0, 0), mout(0, 1), mout(1, 0), mout(1, 1)};
            q.push_back(e);
        end
        exp_v = t;
        if (reset) begin
            mph = 0;
            q.delete();
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 2; c++) begin
                    macc[i][c] = 0;
                    mraw[i][c] = 0;
                end
        end else begin
            mph = t ? mph + R - C : mph + R;
            if (in_valid)
                for (int i = 0; i < 2; i++)
                    for (int c = 0; c < 2; c++) begin
                        x = c ? longint'(in_r) : longint'(in_l);
                        s = i ? 3 : 1;
                        macc[i][c] = macc[i][c] + (((x <<< s) - macc[i][c]) >>> s);
                        mraw[i][c] = x;
                    end
        end
        #1;
        chk("valid_a", out_valid_a, exp_v);
        chk("valid_b", out_valid_b, exp_v);
        chk("tick_a", tick_a, mph + R >= C);
        chk("tick_b", tick_b, mph + R >= C);
        if (out_valid_a) begin
            if (q.size() == 0) chk("sb_depth", q.size(), 1);
            else begin
                e = q.pop_front();
                chk("sb_l_a", out_l_a, e.la);
                chk("sb_r_a", out_r_a, e.ra);
                chk("sb_l_b", out_l_b, e.lb);
                chk("sb_r_b", out_r_b, e.rb);
            end
        end
        if (reset) begin
            chk("rst_l_a", out_l_a, 0);
            chk("rst_r_a", out_r_a, 0);
            chk("rst_l_b", out_l_b, 0);
            chk("rst_r_b", out_r_b, 0);
        end
    endtask

    task automatic wait_ov();
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc();
            seen = out_valid_a;
        end
        chk("ov_timeout", seen, 1);
    endtask

    task automatic wait_tick_next();
        for (int k = 0; k < 20 && !(mph + R >= C); k++) cyc();
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            chk("tick_pat", out_valid_a, (n % 10 == 3) || (n % 10 == 6) || (n % 10 == 9));
        end

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        in_valid = 1'b1;
        in_l = 18'sd1000;
        in_r = -18'sd1000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("step_l", dut_a.u_l.filt, k == 0 ? 500 : k == 1 ? 750 : 875);
            chk("step_r", dut_a.u_r.filt, k == 0 ? -500 : k == 1 ? -750 : -875);
        end

        in_l = 18'sd131071;
        in_r = -18'sd131072;
        repeat (200) cyc();
        in_valid = 1'b0;
        wait_ov();
        chk("ss_l_b", (out_l_b >= 131070) && (out_l_b <= 131071), 1);
        chk("ss_r_b", out_r_b, -131072);

        bypass = 1'b1;
        while (mph + R >= C) cyc();
        in_valid = 1'b1;
        in_l = 18'sd555;
        in_r = -18'sd555;
        cyc();
        in_valid = 1'b0;
        wait_tick_next();
        in_valid = 1'b1;
        in_l = 18'sd1234;
        in_r = -18'sd1234;
        cyc();
        in_valid = 1'b0;
        chk("coll_v", out_valid_a, 1);
        chk("coll_l", out_l_a, 555);
        chk("coll_r_b", out_r_b, -555);
        wait_ov();
        chk("byp_l", out_l_a, 1234);
        chk("byp_r_b", out_r_b, -1234);
        bypass = 1'b0;
        wait_ov();

        for (int k = 0; k < 400; k++) begin
            in_valid = $urandom_range(0, 2) == 0;
            in_l = 18'($urandom);
            in_r = 18'($urandom);
            if ($urandom_range(0, 49) == 0) bypass = ~bypass;
            cyc();
        end
        in_valid = 1'b0;
        bypass = 1'b0;

        wait_tick_next();
        chk("pre_rst_tick", tick_a, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_ov", out_valid_a, 0);
        for (int n = 0; n < 10; n++) begin
            cyc();
            chk("tick_pat2", out_valid_a, (n == 3) || (n == 6) || (n == 9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_rate_adapter.md
Name: audio_rate_adapter

Overview:
- Sits directly upstream of the HDMI video/audio output stage in the clk32 domain.
- Takes raw signed 18-bit stereo core audio samples, which arrive at an arbitrary, irregular strobe rate.
- Low-pass filters each channel with a first-order IIR and re-samples the result onto an exact-average 48 kHz grid using a fractional phase accumulator.
- Presents held 18-bit samples and a one-cycle strobe to the audio_l/audio_r inputs of the output stage.

Parameters:
- CLK_HZ, 31527954, clock frequency in Hz (phase-accumulator modulus).
- RATE_HZ, 48000, output sample rate in Hz; must be < CLK_HZ.
- WIDTH, 18, sample width in bits (signed two's complement).
- SHIFT, 3, IIR coefficient exponent: alpha = 2^-SHIFT; range 1..8.

Ports:
- clk  in  1  system clock (clk32 domain)
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input sample strobe, one cycle per sample
- in_l  in  WIDTH  left input sample, signed
- in_r  in  WIDTH  right input sample, signed
- bypass  in  1  1 = skip the filter; the grid latches the latest raw sample
- out_l  out  WIDTH  held left output sample, signed
- out_r  out  WIDTH  held right output sample, signed
- out_valid  out  1  one-cycle pulse when out_l/out_r update
- tick  out  1  combinational 48 kHz grid tick (debug/bench)

Behaviour:
- Reset (synchronous, active-high): phase, both accumulators, raw-hold registers, out_l, out_r = 0; out_valid = 0. Reset overrides every other event in the same cycle.
- Phase accumulator (unsigned, $clog2(CLK_HZ+RATE_HZ) bits), updated every cycle:
  - tick = (phase + RATE_HZ >= CLK_HZ).
  - tick: phase <= phase + RATE_HZ - CLK_HZ. Otherwise: phase <= phase + RATE_HZ.
  - Exactly RATE_HZ ticks per CLK_HZ cycles; tick spacing jitters by at most 1 cycle.
- Filter, per channel:
  - acc is signed WIDTH+SHIFT bits, carrying SHIFT fraction bits. target = {in, SHIFT'b0}.
  - On in_valid: acc <= acc + ((target - acc) >>> SHIFT).
  - The difference is computed at WIDTH+SHIFT+1 bits. The result is a convex combination, so no overflow or saturation is needed.
  - filt = acc >>> SHIFT (truncation, floor).
- Raw hold: on in_valid, raw <= in. The raw hold is updated in every mode, not only in bypass.
- Output:
  - On a tick cycle, at the next edge: out <= (bypass ? raw : filt), and out_valid <= 1.
  - Otherwise out_valid <= 0 and out holds.
  - Latency: 1 cycle from the tick cycle to out_valid/out.
- Simultaneous in_valid and tick: the output takes the pre-update register value (acc or raw as it stood before this cycle's edge). The new sample appears at the next tick.
- bypass change: takes effect at the next tick. The accumulator keeps filtering while bypass = 1, so returning to filtered mode has no transient.
- in_valid with no ticks (back-to-back input faster than the grid) is legal. Samples only update acc and raw.
- Steady-state accuracy: after a sufficient number of constant inputs x:
  - x <= 0: filt = x exactly.
  - x > 0: filt is in {x-1, x}, because of floor shifting.
- Ticks with no in_valid: out repeats the held value, and out_valid still pulses.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_W = 18.
  - Typedef sample_t (signed [AUDIO_W-1:0]).
  - Typedef stereo_t (struct of l and r sample_t).
- Sub-module audio_iir1 is natural: one channel, parameters WIDTH and SHIFT; ports clk, reset, in_valid, in, filt, raw. Instantiate it twice.
- The phase accumulator and output register stay in the top module.

Test Plan:
- Tick pattern: CLK_HZ=10, RATE_HZ=3, release reset at cycle 0 -> tick on cycles 3,6,9 (0-based, after reset), then repeats with period 10. There are 3 ticks per 10 cycles, and out_valid follows each tick by 1 cycle.
- Rate exactness: default parameters, run 31527954 cycles -> exactly 48000 out_valid pulses; the first tick is at cycle 656 (0-based).
- Filter step: SHIFT=1, in_l=1000 with in_valid every cycle for 3 cycles -> internal filt sequence 500, 750, 875. in_r=-1000 -> -500, -750, -875.
- Steady state: SHIFT=3, 200 valids with in_l=131071 and in_r=-131072 -> at the next out_valid, out_l is in {131070, 131071} and out_r = -131072.
- Bypass and collision:
  - bypass=1, in_valid with in_l=1234 coincident with a tick -> out_l equals the previous raw value.
  - At the next tick, out_l = 1234.
  - Deassert bypass -> out_l = filt with no jump beyond the filter trajectory.
- Reset mid-run: assert reset for 1 cycle during a tick cycle -> no out_valid the following cycle; out_l = out_r = 0. The tick schedule restarts as from power-up.
